// File: rtl/musicbox_pkg.sv
// rtl/musicbox_pkg.sv - shared musicbox constants and note-select helper
package musicbox_pkg;

   localparam int MB_NOTE_COUNT       = 16;
   localparam int MB_NOTE_IDX_W       = 4;
   localparam int MB_OCT_W            = 4;
   localparam int MB_OCT_MIN          = 1;
   localparam int MB_OCT_MAX          = 8;
   localparam int MB_OCT_RESET        = 4;
   localparam int MB_DEBOUNCE_CYCLES  = 1000000;

   typedef struct packed {
      logic [MB_NOTE_COUNT-1:0] sel;
      logic [MB_NOTE_IDX_W-1:0] idx;
   } note_t;

   // Lowest-indexed set bit wins; scanning downward lets the last hit stand.
   function automatic note_t lowest_note(input logic [MB_NOTE_COUNT-1:0] v);
      note_t r;
      r = '0;
      for (int i = MB_NOTE_COUNT - 1; i >= 0; i--) begin
         if (v[i]) begin
            r.sel    = '0;
            r.sel[i] = 1'b1;
            r.idx    = MB_NOTE_IDX_W'(i);
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/debounce_cell.sv
// rtl/debounce_cell.sv - 2-flop synchronizer plus counter debounce for one raw input
module debounce_cell
   import musicbox_pkg::*;
#(
   parameter int   DEBOUNCE_CYCLES = MB_DEBOUNCE_CYCLES,
   parameter logic RESET_LEVEL     = 1'b0,
   parameter bit   REQUIRE_IDLE    = 1'b0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             armed_q, armed_d;
   logic             armed;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // An input held away from its idle level through reset stays ignored until it is seen idle.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      armed   = armed_q | !REQUIRE_IDLE;
      armed_d = armed | (sync2_q == RESET_LEVEL);
      level_d = level_q;
      cnt_d   = '0;
      if (armed && (sync2_q != level_q)) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= RESET_LEVEL;
         armed_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         armed_q <= armed_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;

endmodule

// File: rtl/key_conditioner.sv
// rtl/key_conditioner.sv - debounced note select and octave up/down control
module key_conditioner
   import musicbox_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = MB_DEBOUNCE_CYCLES,
   parameter int OCT_MIN         = MB_OCT_MIN,
   parameter int OCT_MAX         = MB_OCT_MAX,
   parameter int OCT_RESET       = MB_OCT_RESET
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] sw,
   input  logic        btn_left_n,
   input  logic        btn_right_n,
   output logic [15:0] note_sel,
   output logic [3:0]  note_idx,
   output logic        note_valid,
   output logic [3:0]  octave,
   output logic        note_changed,
   output logic        octave_changed
);

   localparam logic [MB_OCT_W-1:0] OCT_LO   = MB_OCT_W'(OCT_MIN);
   localparam logic [MB_OCT_W-1:0] OCT_HI   = MB_OCT_W'(OCT_MAX);
   localparam logic [MB_OCT_W-1:0] OCT_INIT = MB_OCT_W'(OCT_RESET);

   logic [MB_NOTE_COUNT-1:0] sw_level;
   logic                     left_level, right_level;
   logic                     left_ev, right_ev;
   note_t                    note_nxt;

   logic                     left_prev_q, left_prev_d;
   logic                     right_prev_q, right_prev_d;
   logic [MB_NOTE_COUNT-1:0] note_sel_q, note_sel_d;
   logic [MB_NOTE_IDX_W-1:0] note_idx_q, note_idx_d;
   logic                     note_valid_q, note_valid_d;
   logic                     note_changed_q, note_changed_d;
   logic [MB_OCT_W-1:0]      octave_q, octave_d;
   logic                     octave_changed_q, octave_changed_d;

   for (genvar i = 0; i < MB_NOTE_COUNT; i++) begin : g_sw
      debounce_cell #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .RESET_LEVEL     (1'b0),
         .REQUIRE_IDLE    (1'b0)
      ) u_cell (
         .clk   (clk),
         .rst_n (rst_n),
         .raw   (sw[i]),
         .level (sw_level[i])
      );
   end

   debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b1),
      .REQUIRE_IDLE    (1'b1)
   ) u_left (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_left_n),
      .level (left_level)
   );

   debounce_cell #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b1),
      .REQUIRE_IDLE    (1'b1)
   ) u_right (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_right_n),
      .level (right_level)
   );

   always_comb begin
      note_nxt         = lowest_note(sw_level);
      note_sel_d       = note_nxt.sel;
      note_idx_d       = note_nxt.idx;
      note_valid_d     = |note_nxt.sel;
      note_changed_d   = (note_nxt.sel != note_sel_q);

      left_prev_d      = left_level;
      right_prev_d     = right_level;
      left_ev          = left_prev_q & ~left_level;
      right_ev         = right_prev_q & ~right_level;

      // Opposing presses in the same cycle cancel; limits saturate silently.
      octave_d = octave_q;
      if (left_ev && !right_ev && (octave_q > OCT_LO)) begin
         octave_d = octave_q - 1'b1;
      end else if (right_ev && !left_ev && (octave_q < OCT_HI)) begin
         octave_d = octave_q + 1'b1;
      end
      octave_changed_d = (octave_d != octave_q);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_prev_q      <= 1'b1;
         right_prev_q     <= 1'b1;
         note_sel_q       <= '0;
         note_idx_q       <= '0;
         note_valid_q     <= 1'b0;
         note_changed_q   <= 1'b0;
         octave_q         <= OCT_INIT;
         octave_changed_q <= 1'b0;
      end else begin
         left_prev_q      <= left_prev_d;
         right_prev_q     <= right_prev_d;
         note_sel_q       <= note_sel_d;
         note_idx_q       <= note_idx_d;
         note_valid_q     <= note_valid_d;
         note_changed_q   <= note_changed_d;
         octave_q         <= octave_d;
         octave_changed_q <= octave_changed_d;
      end
   end

   assign note_sel       = note_sel_q;
   assign note_idx       = note_idx_q;
   assign note_valid     = note_valid_q;
   assign note_changed   = note_changed_q;
   assign octave         = octave_q;
   assign octave_changed = octave_changed_q;

endmodule

// File: tb/tb_key_conditioner.sv
// tb/tb_key_conditioner.sv - directed self-checking bench for key_conditioner
module tb_key_conditioner;

   logic        clk;
   logic        rst_n;
   logic [15:0] sw;
   logic        btn_left_n;
   logic        btn_right_n;
   logic [15:0] note_sel;
   logic [3:0]  note_idx;
   logic        note_valid;
   logic [3:0]  octave;
   logic        note_changed;
   logic        octave_changed;

   int errors = 0;
   int checks = 0;
   int nc_cnt = 0;
   int oc_cnt = 0;

   key_conditioner #(
      .DEBOUNCE_CYCLES (8)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .sw             (sw),
      .btn_left_n     (btn_left_n),
      .btn_right_n    (btn_right_n),
      .note_sel       (note_sel),
      .note_idx       (note_idx),
      .note_valid     (note_valid),
      .octave         (octave),
      .note_changed   (note_changed),
      .octave_changed (octave_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pulse counters sampled just after each active edge.
   always @(posedge clk) begin
      #1;
      if (note_changed)   nc_cnt++;
      if (octave_changed) oc_cnt++;
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(5);
   endtask

   task automatic press(input bit right);
      if (right) btn_right_n = 1'b0; else btn_left_n = 1'b0;
      tick(12);
      btn_right_n = 1'b1;
      btn_left_n  = 1'b1;
      tick(12);
   endtask

   task automatic test_reset();
      tick(3);
      checks++;
      if (note_sel !== 16'h0000 || note_idx !== 4'd0 || note_valid !== 1'b0 ||
          octave !== 4'd4 || note_changed !== 1'b0 || octave_changed !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: sel=%h idx=%0d valid=%b oct=%0d nc=%b oc=%b, want 0000 0 0 4 0 0",
                  note_sel, note_idx, note_valid, octave, note_changed, octave_changed);
      end
      rst_n = 1'b1;
      tick(5);
      checks++;
      if (note_sel !== 16'h0000 || octave !== 4'd4 || nc_cnt !== 0 || oc_cnt !== 0) begin
         errors++;
         $display("FAIL post_reset_idle: sel=%h oct=%0d nc=%0d oc=%0d, want 0000 4 0 0",
                  note_sel, octave, nc_cnt, oc_cnt);
      end
   endtask

   task automatic test_note_latency();
      int nc0;
      nc0 = nc_cnt;
      sw = 16'h0020;
      tick(1);
      tick(9);
      checks++;
      if (note_sel !== 16'h0000) begin
         errors++;
         $display("FAIL note_too_early: sel=%h, want 0000", note_sel);
      end
      tick(1);
      checks++;
      if (note_sel !== 16'h0020 || note_idx !== 4'd5 || note_valid !== 1'b1 || note_changed !== 1'b1) begin
         errors++;
         $display("FAIL note_latency: sel=%h idx=%0d valid=%b nc=%b, want 0020 5 1 1",
                  note_sel, note_idx, note_valid, note_changed);
      end
      tick(5);
      checks++;
      if (nc_cnt - nc0 !== 1) begin
         errors++;
         $display("FAIL note_single_pulse: pulses=%0d, want 1", nc_cnt - nc0);
      end
      sw = 16'h0000;
      tick(14);
   endtask

   task automatic test_glitch();
      int nc0;
      nc0 = nc_cnt;
      sw = 16'h0008;
      tick(5);
      sw = 16'h0000;
      tick(20);
      checks++;
      if (note_sel !== 16'h0000 || nc_cnt - nc0 !== 0) begin
         errors++;
         $display("FAIL glitch_rejected: sel=%h pulses=%0d, want 0000 0", note_sel, nc_cnt - nc0);
      end
   endtask

   task automatic test_priority();
      int nc0;
      nc0 = nc_cnt;
      sw = 16'h0A00;
      tick(12);
      checks++;
      if (note_sel !== 16'h0200 || note_idx !== 4'd9 || note_valid !== 1'b1 || nc_cnt - nc0 !== 1) begin
         errors++;
         $display("FAIL note_priority: sel=%h idx=%0d valid=%b pulses=%0d, want 0200 9 1 1",
                  note_sel, note_idx, note_valid, nc_cnt - nc0);
      end
      sw = 16'h0000;
      tick(12);
      checks++;
      if (note_sel !== 16'h0000 || note_idx !== 4'd0 || note_valid !== 1'b0 || nc_cnt - nc0 !== 2) begin
         errors++;
         $display("FAIL note_silence: sel=%h idx=%0d valid=%b pulses=%0d, want 0000 0 0 2",
                  note_sel, note_idx, note_valid, nc_cnt - nc0);
      end
   endtask

   task automatic test_octave_up();
      logic [3:0] exp_oct [6] = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd8, 4'd8};
      int oc0;
      oc0 = oc_cnt;
      for (int i = 0; i < 6; i++) begin
         press(1'b1);
         checks++;
         if (octave !== exp_oct[i]) begin
            errors++;
            $display("FAIL octave_up_%0d: octave=%0d, want %0d", i, octave, exp_oct[i]);
         end
      end
      checks++;
      if (oc_cnt - oc0 !== 4) begin
         errors++;
         $display("FAIL octave_up_pulses: pulses=%0d, want 4", oc_cnt - oc0);
      end
   endtask

   task automatic test_both_then_left();
      int oc0;
      apply_reset();
      oc0 = oc_cnt;
      btn_left_n  = 1'b0;
      btn_right_n = 1'b0;
      tick(20);
      checks++;
      if (octave !== 4'd4 || oc_cnt - oc0 !== 0) begin
         errors++;
         $display("FAIL both_pressed: octave=%0d pulses=%0d, want 4 0", octave, oc_cnt - oc0);
      end
      btn_left_n  = 1'b1;
      btn_right_n = 1'b1;
      tick(12);
      btn_left_n = 1'b0;
      tick(100);
      checks++;
      if (octave !== 4'd3 || oc_cnt - oc0 !== 1) begin
         errors++;
         $display("FAIL left_held: octave=%0d pulses=%0d, want 3 1", octave, oc_cnt - oc0);
      end
      btn_left_n = 1'b1;
      tick(12);
   endtask

   task automatic test_left_saturate();
      logic [3:0] exp_oct [3] = '{4'd2, 4'd1, 4'd1};
      int oc0;
      oc0 = oc_cnt;
      for (int i = 0; i < 3; i++) begin
         press(1'b0);
         checks++;
         if (octave !== exp_oct[i]) begin
            errors++;
            $display("FAIL octave_down_%0d: octave=%0d, want %0d", i, octave, exp_oct[i]);
         end
      end
      checks++;
      if (oc_cnt - oc0 !== 2) begin
         errors++;
         $display("FAIL octave_down_pulses: pulses=%0d, want 2", oc_cnt - oc0);
      end
   endtask

   task automatic test_reset_mid();
      int oc0;
      apply_reset();
      for (int i = 0; i < 3; i++) press(1'b1);
      checks++;
      if (octave !== 4'd7) begin
         errors++;
         $display("FAIL reach_seven: octave=%0d, want 7", octave);
      end
      btn_right_n = 1'b0;
      tick(5);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (octave !== 4'd4 || note_sel !== 16'h0000 || octave_changed !== 1'b0 || note_changed !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: octave=%0d sel=%h oc=%b nc=%b, want 4 0000 0 0",
                  octave, note_sel, octave_changed, note_changed);
      end
      tick(3);
      rst_n = 1'b1;
      oc0 = oc_cnt;
      tick(30);
      checks++;
      if (octave !== 4'd4 || oc_cnt - oc0 !== 0) begin
         errors++;
         $display("FAIL held_through_reset: octave=%0d pulses=%0d, want 4 0", octave, oc_cnt - oc0);
      end
      btn_right_n = 1'b1;
      tick(12);
      press(1'b1);
      checks++;
      if (octave !== 4'd5 || oc_cnt - oc0 !== 1) begin
         errors++;
         $display("FAIL repress_after_reset: octave=%0d pulses=%0d, want 5 1", octave, oc_cnt - oc0);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      sw          = 16'h0000;
      btn_left_n  = 1'b1;
      btn_right_n = 1'b1;
      test_reset();
      test_note_latency();
      test_glitch();
      test_priority();
      test_octave_up();
      test_both_then_left();
      test_left_saturate();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
